// File: rtl/std_mult_seq.sv
// std_mult_seq -- iterative shift-add unsigned multiplier.
//
// Retires one multiplier bit per clock and returns the full double-width
// product as a low word (out) and a high word (out_hi). A request is made
// by holding go high; done pulses for exactly one cycle when the result
// registers are updated. Dropping go while iterating abandons the operation
// without touching the result registers.
//
// Parameters:
//   width   operand width in bits (>= 2); both product halves are this wide
//
// Ports:
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high; clears all state
//   go      in   1      request, held until done is seen
//   left    in   width  multiplicand, sampled only at start
//   right   in   width  multiplier, sampled only at start
//   out     out  width  low half of left*right, registered
//   out_hi  out  width  high half of left*right, registered
//   done    out  1      one-cycle completion pulse, registered
//
// Build option:
//   STD_MULT_SEQ_EARLY_EXIT_EN  when defined, iteration also stops as soon
//   as the remaining multiplier bits are all zero, giving a data-dependent
//   latency with identical results. Left undefined, every nonzero operand
//   pair takes a fixed width+1 edges.

module std_mult_seq #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out,
    output logic [width-1:0] out_hi,
    output logic             done
);

    localparam int count_w = $clog2(width + 1);
    localparam logic [count_w-1:0] last_count = count_w'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2*width-1:0] acc, acc_next;
    logic [2*width-1:0] mcand, mcand_next;
    logic [width-1:0]   mplier, mplier_next;
    logic [count_w-1:0] count, count_next;
    logic [width-1:0]   out_next, out_hi_next;
    logic               done_next;

    logic [2*width-1:0] acc_step;
    logic [width-1:0]   mplier_shift;
    logic               last_step;
    logic               zero_operand;

    // One iteration of the shift-add recurrence. The accumulator is
    // double width, so adding the shifted multiplicand can never carry out.
    always_comb begin
        acc_step     = mplier[0] ? (acc + mcand) : acc;
        mplier_shift = mplier >> 1;
        zero_operand = (left == '0) || (right == '0);
    end

    // The step being taken is the final one either when every multiplier
    // bit has been consumed or, in the early-exit build, when no set bits
    // remain above the current position.
`ifdef STD_MULT_SEQ_EARLY_EXIT_EN
    assign last_step = (count == last_count) || (mplier_shift == '0);
`else
    assign last_step = (count == last_count);
`endif

    // Next-state and next-datapath logic. Everything holds by default so
    // that an abort leaves the result registers untouched and done low.
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        mcand_next  = mcand;
        mplier_next = mplier;
        count_next  = count;
        out_next    = out;
        out_hi_next = out_hi;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                if (go) begin
                    if (zero_operand) begin
                        // Product is trivially zero; skip the iteration.
                        out_next    = '0;
                        out_hi_next = '0;
                        done_next   = 1'b1;
                        state_next  = DONE;
                    end else begin
                        acc_next    = '0;
                        mcand_next  = {{width{1'b0}}, left};
                        mplier_next = right;
                        count_next  = '0;
                        state_next  = RUN;
                    end
                end
            end

            RUN: begin
                if (!go) begin
                    state_next = IDLE;
                end else begin
                    acc_next    = acc_step;
                    mcand_next  = mcand << 1;
                    mplier_next = mplier_shift;
                    count_next  = count + count_w'(1);
                    if (last_step) begin
                        {out_hi_next, out_next} = acc_step;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                // go is deliberately ignored here; a held request restarts
                // from IDLE on the following edge with fresh operands.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            out    <= '0;
            out_hi <= '0;
            done   <= 1'b0;
        end else begin
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            count  <= count_next;
            out    <= out_next;
            out_hi <= out_hi_next;
            done   <= done_next;
        end
    end

endmodule
